// File: rtl/pixel_counter_pkg.sv
// -----------------------------------------------------------------------------
// pixel_counter_pkg
//   Shared definitions for the pixel ramp conversion counter:
//     - state_t         : conversion FSM states (IDLE, COUNT)
//     - DEFAULT_*       : default BIT_DEPTH / PRESCALE_W values
//     - GRAY_FN_W       : working width of bin_to_gray (callers cast in/out)
//     - bin_to_gray()   : binary to reflected Gray code conversion
// -----------------------------------------------------------------------------
package pixel_counter_pkg;

   localparam int DEFAULT_BIT_DEPTH  = 8;
   localparam int DEFAULT_PRESCALE_W = 4;

   // bin_to_gray works on a fixed wide word so any BIT_DEPTH up to this
   // width can use it; callers zero-extend the input and truncate the result.
   localparam int GRAY_FN_W = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   function automatic logic [GRAY_FN_W-1:0] bin_to_gray(
      input logic [GRAY_FN_W-1:0] bin
   );
      return bin ^ (bin >> 1);
   endfunction

endpackage : pixel_counter_pkg

// File: rtl/pixel_ramp_prescaler.sv
// -----------------------------------------------------------------------------
// pixel_ramp_prescaler
//   Clock divider for the ramp counter. Holds the prescale value latched at
//   conversion start and a free-running prescale counter; o_tick is high on
//   the clock where the count is allowed to advance (every PRESCALE+1 clocks).
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_load       conversion accepted: latch i_prescale, clear counter
//   i_clear      conversion aborted: clear counter
//   i_run        conversion active (counter advances only while high)
//   i_prescale   prescale value to latch on i_load
//   o_tick       advance strobe, valid while i_run is high
// -----------------------------------------------------------------------------
module pixel_ramp_prescaler import pixel_counter_pkg::*; #(
   parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_load,
   input  logic                  i_clear,
   input  logic                  i_run,
   input  logic [PRESCALE_W-1:0] i_prescale,
   output logic                  o_tick
);

   logic [PRESCALE_W-1:0] r_prescale;
   logic [PRESCALE_W-1:0] r_cnt;
   logic                  w_wrap;

   // The counter wraps when it reaches the latched value, so a prescale of P
   // yields one tick every P+1 clocks and P=0 ticks every clock.
   assign w_wrap = (r_cnt == r_prescale);
   assign o_tick = i_run && w_wrap;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prescale <= '0;
         r_cnt      <= '0;
      end else begin
         if (i_load) begin
            r_prescale <= i_prescale;
            r_cnt      <= '0;
         end else if (i_clear) begin
            r_cnt      <= '0;
         end else if (i_run) begin
            if (w_wrap) begin
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

endmodule : pixel_ramp_prescaler

// File: rtl/pixel_ramp_counter.sv
// -----------------------------------------------------------------------------
// pixel_ramp_counter
//   Start/stop conversion counter broadcast to the pixel memories. Counts from
//   0 to a terminal value latched at START, advancing once per prescaler tick,
//   then pulses DONE for one cycle. ABORT ends a conversion without DONE.
//
// Optional build macro:
//   PIXEL_RAMP_COUNTER_GRAY_OUTPUT_EN  DATA carries the Gray code of the
//                                      internal binary count (same latency).
//                                      Undefined: DATA is plain binary.
//
// Ports:
//   COUNTER_CLOCK     clock, rising edge
//   COUNTER_RESET_N   asynchronous active-low reset
//   START             one-cycle conversion request, ignored while BUSY
//   ABORT             terminate the active conversion (beats START and tick)
//   MAX_COUNT         terminal count, latched on accepted START
//   PRESCALE          count every PRESCALE+1 clocks, latched on accepted START
//   DATA              registered count (binary or Gray)
//   BUSY              high exactly while the FSM is in COUNT
//   DONE              registered one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module pixel_ramp_counter import pixel_counter_pkg::*; #(
   parameter int BIT_DEPTH  = DEFAULT_BIT_DEPTH,
   parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
   input  logic                  COUNTER_CLOCK,
   input  logic                  COUNTER_RESET_N,
   input  logic                  START,
   input  logic                  ABORT,
   input  logic [BIT_DEPTH-1:0]  MAX_COUNT,
   input  logic [PRESCALE_W-1:0] PRESCALE,
   output logic [BIT_DEPTH-1:0]  DATA,
   output logic                  BUSY,
   output logic                  DONE
);

   state_t                r_state;
   logic [BIT_DEPTH-1:0]  r_count;
   logic [BIT_DEPTH-1:0]  r_max;
   logic [BIT_DEPTH-1:0]  r_data;
   logic                  r_done;

   logic                  w_counting;
   logic                  w_start_accept;
   logic                  w_abort;
   logic                  w_tick;
   logic                  w_terminal;
   logic [BIT_DEPTH-1:0]  w_count_inc;
   logic [BIT_DEPTH-1:0]  w_data_inc;

   assign w_counting     = (r_state == COUNT);
   // ABORT wins over a simultaneous START in IDLE.
   assign w_start_accept = (r_state == IDLE) && START && !ABORT;
   assign w_abort        = w_counting && ABORT;
   assign w_terminal     = (r_count == r_max);
   assign w_count_inc    = r_count + 1'b1;

   // DATA is encoded from the next binary count so the encoded output is
   // registered with the same latency as the binary count itself.
`ifdef PIXEL_RAMP_COUNTER_GRAY_OUTPUT_EN
   assign w_data_inc = BIT_DEPTH'(bin_to_gray(GRAY_FN_W'(w_count_inc)));
`else
   assign w_data_inc = w_count_inc;
`endif

   pixel_ramp_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .i_clk      (COUNTER_CLOCK),
      .i_rst_n    (COUNTER_RESET_N),
      .i_load     (w_start_accept),
      .i_clear    (w_abort),
      .i_run      (w_counting),
      .i_prescale (PRESCALE),
      .o_tick     (w_tick)
   );

   always_ff @(posedge COUNTER_CLOCK or negedge COUNTER_RESET_N) begin
      if (!COUNTER_RESET_N) begin
         r_state <= IDLE;
         r_count <= '0;
         r_max   <= '0;
         r_data  <= '0;
         r_done  <= 1'b0;
      end else begin
         // DONE is a single-cycle pulse; every path below that does not
         // complete a conversion leaves it low.
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               // DATA holds its last value while idle.
               if (w_start_accept) begin
                  r_state <= COUNT;
                  r_count <= '0;
                  r_data  <= '0;
                  r_max   <= MAX_COUNT;
               end
            end
            COUNT: begin
               if (ABORT) begin
                  r_state <= IDLE;
               end else if (w_tick) begin
                  // Terminal compare is always on the binary count, so the
                  // count stops at MAX and never wraps.
                  if (w_terminal) begin
                     r_state <= IDLE;
                     r_done  <= 1'b1;
                  end else begin
                     r_count <= w_count_inc;
                     r_data  <= w_data_inc;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign DATA = r_data;
   assign BUSY = w_counting;
   assign DONE = r_done;

endmodule : pixel_ramp_counter

// File: doc/pixel_ramp_counter.md
Name: pixel_ramp_counter

Overview:
- Parametrised, start/stop-controlled conversion counter for the digital pixel sensor array.
- Driven by the readout controller at the start of each ramp conversion; broadcasts the count to every pixel memory.
- Counts from 0 to a programmable terminal value. A programmable prescaler sets the count rate.
- Returns a one-cycle DONE pulse when the conversion completes. ABORT terminates the conversion early.

Parameters:
- BIT_DEPTH, 8, width of DATA and MAX_COUNT.
- PRESCALE_W, 4, width of the PRESCALE input.

Ports:
- COUNTER_CLOCK    input   1           sole clock, rising edge
- COUNTER_RESET_N  input   1           asynchronous, active-low reset
- START            input   1           single-cycle request to begin a conversion; ignored while BUSY
- ABORT            input   1           terminates an active conversion
- MAX_COUNT        input   BIT_DEPTH   terminal count, binary; latched on accepted START
- PRESCALE         input   PRESCALE_W  count advances every PRESCALE+1 clocks; latched on accepted START
- DATA             output  BIT_DEPTH   current count, registered
- BUSY             output  1           high while a conversion is active
- DONE             output  1           one-cycle pulse on normal completion

Behaviour:
- Interface: one clock COUNTER_CLOCK. Reset COUNTER_RESET_N is asynchronous and active-low.
- Reset, asynchronous on the falling edge of COUNTER_RESET_N:
  - DATA=0, BUSY=0, DONE=0.
  - State IDLE; prescaler=0; latched MAX/PRESCALE=0.
  - Applies mid-conversion as well; no DONE is produced.
- States: IDLE, COUNT. BUSY is 1 exactly when the state is COUNT. DONE is a registered output.
- IDLE:
  - START=1 and ABORT=0 → next edge: state COUNT, DATA=0, prescaler=0, MAX_COUNT and PRESCALE latched.
  - START=1 and ABORT=1 → ABORT wins; remain IDLE, nothing latched.
  - DATA holds its last value while IDLE.
- COUNT, each edge:
  - If ABORT=1: go IDLE. DATA holds, DONE stays 0, prescaler cleared. ABORT has priority over a tick.
  - Else if prescaler != latched PRESCALE: prescaler+1.
  - Else (tick): prescaler←0.
    - If internal count == latched MAX: go IDLE, DONE=1 for one cycle, DATA holds MAX.
    - Otherwise count+1.
- START is ignored while BUSY. DONE returns to 0 on the following edge regardless of inputs.
- Timing: START sampled at edge n → BUSY=1 and DATA=0 after edge n.
  - Increments occur after edges n+k(P+1), k=1..MAX.
  - DONE=1 and BUSY=0 after edge n+(MAX+1)(P+1).
- Width rules:
  - Internal count is a BIT_DEPTH-bit binary value and never wraps; the terminal compare stops it at MAX ≤ 2^BIT_DEPTH−1.
  - MAX_COUNT=0: DATA stays 0 and DONE arrives after P+1 cycles.
  - PRESCALE=0: one count per clock.
- MAX_COUNT and PRESCALE changing during COUNT have no effect.

Optional Feature:
- Macro PIXEL_RAMP_COUNTER_GRAY_OUTPUT_EN.
- Defined: DATA carries the Gray code of the internal binary count, computed as bin ^ (bin>>1). It is registered with the same latency as binary mode, so only one bit toggles per increment, which avoids multi-bit glitches at the pixel latches. The terminal compare still uses the binary count against binary MAX_COUNT. Reset value is 0.
- Undefined: DATA is the plain binary count.

Decomposition:
- Package pixel_counter_pkg:
  - state enum (IDLE, COUNT);
  - default BIT_DEPTH and PRESCALE_W constants;
  - function bin_to_gray.
- One natural sub-module: pixel_ramp_prescaler. It holds the prescaler register and the latched PRESCALE, and emits the tick. Clear on START accept, ABORT and reset.
- The FSM, count register, terminal compare and DATA encoding stay in the top module.

Test Plan:
1. MAX_COUNT=3, PRESCALE=0, pulse START → DATA 0,1,2,3 on successive edges; DONE=1 and BUSY=0 after the 4th edge post-START; DATA stays 3.
2. MAX_COUNT=2, PRESCALE=2 → DATA changes every 3 cycles (0,1,2); DONE after edge 9; changing PRESCALE to 0 mid-run has no effect.
3. MAX_COUNT=255, PRESCALE=0 → DATA reaches 255, then DONE; DATA never wraps to 0; a START pulsed at DATA=100 is ignored.
4. ABORT at DATA=10 → BUSY=0 next edge, DATA=10 holds, DONE never asserted; a new START restarts from DATA=0.
5. COUNTER_RESET_N low at DATA=5 → DATA=0, BUSY=0, DONE=0 immediately, without a clock edge; after release, IDLE until START. Also START and ABORT together in IDLE → stays IDLE.
6. With PIXEL_RAMP_COUNTER_GRAY_OUTPUT_EN, MAX_COUNT=7, PRESCALE=0 → DATA 0,1,3,2,6,7,5,4, then DONE with DATA=4.
